// File: rtl/fir_stream.sv
// Transposed-form streaming FIR: y[n] = sum c[k]*x[n-k] with zero history at each packet start.
// Latency: 1 cycle from input acceptance to m00_axis_tvalid, one sample per cycle sustained.
// Backpressure: one-deep output register; input ready only while the output slot is free or draining.
module fir_stream #(
    parameter int C_S00_AXIS_TDATA_WIDTH = 32,
    parameter int C_M00_AXIS_TDATA_WIDTH = 32,
    parameter int NUM_TAPS               = 8,
    parameter int COEFF_WIDTH            = 8,
    parameter int SATURATE               = 0
) (
    input  logic                                     clk,
    input  logic                                     rst_in,
    input  logic                                     s00_axis_tvalid,
    output logic                                     s00_axis_tready,
    input  logic signed [C_S00_AXIS_TDATA_WIDTH-1:0] s00_axis_tdata,
    input  logic                                     s00_axis_tlast,
    output logic                                     m00_axis_tvalid,
    input  logic                                     m00_axis_tready,
    output logic signed [C_M00_AXIS_TDATA_WIDTH-1:0] m00_axis_tdata,
    output logic                                     m00_axis_tlast,
    input  logic                                     coeff_wr,
    input  logic        [$clog2(NUM_TAPS)-1:0]       coeff_addr,
    input  logic signed [COEFF_WIDTH-1:0]            coeff_data,
    output logic                                     busy
);

    localparam int IN_W  = C_S00_AXIS_TDATA_WIDTH;
    localparam int OUT_W = C_M00_AXIS_TDATA_WIDTH;
    localparam int AW    = $clog2(NUM_TAPS);
    // Wide enough that a full sum of NUM_TAPS worst-case products never overflows.
    localparam int ACC_W = IN_W + COEFF_WIDTH + AW;

    typedef enum logic {
        IDLE    = 1'b0,
        RUNNING = 1'b1
    } state_t;

    state_t                    state_q;
    logic                      busy_q;
    logic signed [COEFF_WIDTH-1:0] c_q  [NUM_TAPS];
    logic signed [ACC_W-1:0]   z_q  [NUM_TAPS-1];
    logic signed [ACC_W-1:0]   z_d  [NUM_TAPS-1];
    logic signed [ACC_W-1:0]   prod [NUM_TAPS];
    logic signed [ACC_W-1:0]   acc;
    logic signed [OUT_W-1:0]   y_res;
    logic signed [OUT_W-1:0]   m_dat_q;
    logic                      m_vld_q;
    logic                      m_last_q;
    logic                      accept;

    assign s00_axis_tready = !m_vld_q || m00_axis_tready;
    assign accept          = s00_axis_tvalid && s00_axis_tready;
    assign m00_axis_tvalid = m_vld_q;
    assign m00_axis_tdata  = m_dat_q;
    assign m00_axis_tlast  = m_last_q;
    assign busy            = busy_q;

    // Broadcast the input sample to every tap and form the next partial-sum chain.
    always_comb begin
        for (int k = 0; k < NUM_TAPS; k++) begin
            prod[k] = ACC_W'(s00_axis_tdata) * ACC_W'(c_q[k]);
        end
        for (int k = 0; k < NUM_TAPS - 2; k++) begin
            z_d[k] = prod[k+1] + z_q[k+1];
        end
        z_d[NUM_TAPS-2] = prod[NUM_TAPS-1];
        acc = prod[0] + z_q[0];
    end

    // Reduce the full-precision result to the output width.
    generate
        if (OUT_W >= ACC_W) begin : g_ext
            assign y_res = OUT_W'(acc);
        end else if (SATURATE != 0) begin : g_sat
            localparam logic signed [ACC_W-1:0] SAT_MAX =
                {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
            localparam logic signed [ACC_W-1:0] SAT_MIN =
                {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
            // Clamp out-of-range sums to the nearest representable output value.
            always_comb begin
                y_res = acc[OUT_W-1:0];
                if (acc > SAT_MAX) begin
                    y_res = SAT_MAX[OUT_W-1:0];
                end else if (acc < SAT_MIN) begin
                    y_res = SAT_MIN[OUT_W-1:0];
                end
            end
        end else begin : g_wrap
            assign y_res = acc[OUT_W-1:0];
        end
    endgenerate

    // Output register and partial-sum history; tlast wipes history for the next packet.
    always_ff @(posedge clk) begin
        if (rst_in) begin
            m_vld_q  <= 1'b0;
            m_last_q <= 1'b0;
            m_dat_q  <= '0;
            for (int k = 0; k < NUM_TAPS - 1; k++) begin
                z_q[k] <= '0;
            end
        end else if (accept) begin
            m_vld_q  <= 1'b1;
            m_last_q <= s00_axis_tlast;
            m_dat_q  <= y_res;
            for (int k = 0; k < NUM_TAPS - 1; k++) begin
                z_q[k] <= s00_axis_tlast ? '0 : z_d[k];
            end
        end else if (m00_axis_tready) begin
            m_vld_q <= 1'b0;
        end
    end

    // Packet tracking FSM; busy is registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst_in) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept && !s00_axis_tlast) begin
                        state_q <= RUNNING;
                        busy_q  <= 1'b1;
                    end
                end
                RUNNING: begin
                    if (accept && s00_axis_tlast) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Coefficients change only between packets so a packet never sees mixed taps.
    always_ff @(posedge clk) begin
        if (rst_in) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                c_q[k] <= (k == 0) ? {{(COEFF_WIDTH-1){1'b0}}, 1'b1} : '0;
            end
        end else if (coeff_wr && (state_q == IDLE) && !accept
                     && (int'(coeff_addr) < NUM_TAPS)) begin
            c_q[coeff_addr] <= coeff_data;
        end
    end

endmodule

// File: tb/tb_fir_stream.sv
// Directed bench for fir_stream: impulse, backpressure, packet boundary, saturation,
// coefficient write guard and mid-packet reset, with hand-computed expectations.
// Three instances share stimulus: 32-bit wrap, 8-bit saturating and 8-bit wrapping outputs.
module tb_fir_stream;

    logic               clk = 1'b0;
    logic               rst_in;
    logic               s_vld;
    logic signed [15:0] s_dat;
    logic               s_last;
    logic               m_rdy;
    logic               coeff_wr;
    logic        [1:0]  coeff_addr;
    logic signed [7:0]  coeff_data;

    logic               s_rdy, s_rdy_sat, s_rdy_w8;
    logic               m_vld, m_vld_sat, m_vld_w8;
    logic signed [31:0] m_dat;
    logic signed [7:0]  m_dat_sat, m_dat_w8;
    logic               m_last, m_last_sat, m_last_w8;
    logic               busy, busy_sat, busy_w8;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fir_stream #(
        .C_S00_AXIS_TDATA_WIDTH(16), .C_M00_AXIS_TDATA_WIDTH(32),
        .NUM_TAPS(4), .COEFF_WIDTH(8), .SATURATE(0)
    ) u_dut (
        .clk(clk), .rst_in(rst_in),
        .s00_axis_tvalid(s_vld), .s00_axis_tready(s_rdy),
        .s00_axis_tdata(s_dat), .s00_axis_tlast(s_last),
        .m00_axis_tvalid(m_vld), .m00_axis_tready(m_rdy),
        .m00_axis_tdata(m_dat), .m00_axis_tlast(m_last),
        .coeff_wr(coeff_wr), .coeff_addr(coeff_addr), .coeff_data(coeff_data),
        .busy(busy)
    );

    fir_stream #(
        .C_S00_AXIS_TDATA_WIDTH(16), .C_M00_AXIS_TDATA_WIDTH(8),
        .NUM_TAPS(4), .COEFF_WIDTH(8), .SATURATE(1)
    ) u_sat (
        .clk(clk), .rst_in(rst_in),
        .s00_axis_tvalid(s_vld), .s00_axis_tready(s_rdy_sat),
        .s00_axis_tdata(s_dat), .s00_axis_tlast(s_last),
        .m00_axis_tvalid(m_vld_sat), .m00_axis_tready(m_rdy),
        .m00_axis_tdata(m_dat_sat), .m00_axis_tlast(m_last_sat),
        .coeff_wr(coeff_wr), .coeff_addr(coeff_addr), .coeff_data(coeff_data),
        .busy(busy_sat)
    );

    fir_stream #(
        .C_S00_AXIS_TDATA_WIDTH(16), .C_M00_AXIS_TDATA_WIDTH(8),
        .NUM_TAPS(4), .COEFF_WIDTH(8), .SATURATE(0)
    ) u_w8 (
        .clk(clk), .rst_in(rst_in),
        .s00_axis_tvalid(s_vld), .s00_axis_tready(s_rdy_w8),
        .s00_axis_tdata(s_dat), .s00_axis_tlast(s_last),
        .m00_axis_tvalid(m_vld_w8), .m00_axis_tready(m_rdy),
        .m00_axis_tdata(m_dat_w8), .m00_axis_tlast(m_last_w8),
        .coeff_wr(coeff_wr), .coeff_addr(coeff_addr), .coeff_data(coeff_data),
        .busy(busy_w8)
    );

    task automatic chk_val(input string tag, input logic signed [63:0] obs,
                           input logic signed [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_coeff(input int addr, input int data);
        coeff_wr   = 1'b1;
        coeff_addr = 2'(addr);
        coeff_data = 8'(data);
        tick();
        coeff_wr   = 1'b0;
    endtask

    task automatic send(input int data, input logic last);
        s_vld  = 1'b1;
        s_dat  = 16'(data);
        s_last = last;
        tick();
        s_vld  = 1'b0;
        s_last = 1'b0;
    endtask

    task automatic send_chk(input string tag, input int data, input logic last,
                            input int exp);
        send(data, last);
        chk_val({tag, "_vld"}, 64'(m_vld), 64'(1));
        chk_val({tag, "_dat"}, 64'(m_dat), 64'(exp));
        chk_val({tag, "_last"}, 64'(m_last), 64'(last));
    endtask

    initial begin
        rst_in     = 1'b1;
        s_vld      = 1'b0;
        s_dat      = '0;
        s_last     = 1'b0;
        m_rdy      = 1'b1;
        coeff_wr   = 1'b0;
        coeff_addr = '0;
        coeff_data = '0;
        tick();
        tick();
        rst_in = 1'b0;

        // Reset state; identity filter means a bare sample passes through.
        chk_val("rst_vld", 64'(m_vld), 64'(0));
        chk_val("rst_last", 64'(m_last), 64'(0));
        chk_val("rst_dat", 64'(m_dat), 64'(0));
        chk_val("rst_busy", 64'(busy), 64'(0));
        chk_val("rst_srdy", 64'(s_rdy), 64'(1));

        // Impulse with c = {1,2,3,4}.
        wr_coeff(1, 2);
        wr_coeff(2, 3);
        wr_coeff(3, 4);
        send_chk("imp0", 1, 1'b0, 1);
        chk_val("imp_busy", 64'(busy), 64'(1));
        send_chk("imp1", 0, 1'b0, 2);
        send_chk("imp2", 0, 1'b0, 3);
        send_chk("imp3", 0, 1'b1, 4);
        chk_val("imp_idle", 64'(busy), 64'(0));
        tick();
        chk_val("imp_drain", 64'(m_vld), 64'(0));

        // Backpressure with c = {1,1,1,1}.
        wr_coeff(1, 1);
        wr_coeff(2, 1);
        wr_coeff(3, 1);
        send_chk("bp0", 5, 1'b0, 5);
        m_rdy  = 1'b0;
        s_vld  = 1'b1;
        s_dat  = 16'sd5;
        #1;
        chk_val("bp_srdy", 64'(s_rdy), 64'(0));
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_val("bp_hold_vld", 64'(m_vld), 64'(1));
            chk_val("bp_hold_dat", 64'(m_dat), 64'(5));
            chk_val("bp_hold_srdy", 64'(s_rdy), 64'(0));
        end
        m_rdy = 1'b1;
        send_chk("bp1", 5, 1'b0, 10);
        send_chk("bp2", 5, 1'b0, 15);
        send_chk("bp3", 5, 1'b1, 20);
        tick();

        // Packet boundary with c = {1,1,0,0}: B must not see A's history.
        wr_coeff(2, 0);
        wr_coeff(3, 0);
        send_chk("pktA0", 7, 1'b0, 7);
        send_chk("pktA1", 9, 1'b1, 16);
        send_chk("pktB0", 3, 1'b1, 3);
        chk_val("pktB_idle", 64'(busy), 64'(0));
        tick();

        // Coefficient write guard: c = {1,0,0,0}, write c[1]=5 while busy.
        wr_coeff(1, 0);
        send_chk("cw0", 2, 1'b0, 2);
        wr_coeff(1, 5);
        send_chk("cw_busy", 3, 1'b1, 3);
        wr_coeff(1, 5);
        send_chk("cw_idle0", 2, 1'b0, 2);
        send_chk("cw_idle1", 3, 1'b1, 13);
        tick();

        // Saturation / wrap with c = {127,0,0,0}.
        wr_coeff(1, 0);
        wr_coeff(0, 127);
        send(100, 1'b1);
        chk_val("sat_pos", 64'(m_dat_sat), 64'(127));
        chk_val("wrap8_pos", 64'(m_dat_w8), -64'sd100);
        chk_val("wide_pos", 64'(m_dat), 64'(12700));
        send(-100, 1'b1);
        chk_val("sat_neg", 64'(m_dat_sat), -64'sd128);
        chk_val("wide_neg", 64'(m_dat), -64'sd12700);
        tick();

        // Reset mid-packet with c = {2,1,1,1}.
        wr_coeff(0, 2);
        wr_coeff(1, 1);
        wr_coeff(2, 1);
        wr_coeff(3, 1);
        send_chk("mid0", 1, 1'b0, 2);
        send_chk("mid1", 1, 1'b0, 3);
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        chk_val("mid_rst_vld", 64'(m_vld), 64'(0));
        chk_val("mid_rst_busy", 64'(busy), 64'(0));
        send_chk("mid_post", 6, 1'b1, 6);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
